// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, data width and legal-opcode check
package alu_pkg;
  localparam int DATA_W = 32;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester ports and the response port of the shared ALU
interface alu_arbiter_if;
  import alu_pkg::*;
  logic              i_r0_valid, i_r1_valid, o_r0_ready, o_r1_ready;
  logic [DATA_W-1:0] i_r0_operand1, i_r0_operand2, i_r1_operand1, i_r1_operand2;
  logic [3:0]        i_r0_ALUControl, i_r1_ALUControl;
  logic              o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_zero, o_rsp_neg, o_rsp_illegal, o_busy;
  logic [DATA_W-1:0] o_rsp_result;
  modport slave (
    input  i_r0_valid, i_r1_valid, i_r0_operand1, i_r0_operand2, i_r1_operand1, i_r1_operand2,
    input  i_r0_ALUControl, i_r1_ALUControl, i_rsp_ready,
    output o_r0_ready, o_r1_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_zero, o_rsp_neg,
    output o_rsp_illegal, o_busy
  );
  modport master (
    output i_r0_valid, i_r1_valid, i_r0_operand1, i_r0_operand2, i_r1_operand1, i_r1_operand2,
    output i_r0_ALUControl, i_r1_ALUControl, i_rsp_ready,
    input  o_r0_ready, o_r1_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_zero, o_rsp_neg,
    input  o_rsp_illegal, o_busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// ALU: combinational 32-bit ALU, undefined opcodes yield zero
module ALU
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] operand1_i,
  input  logic [DATA_W-1:0] operand2_i,
  input  logic [3:0]        alu_control_i,
  output logic [DATA_W-1:0] result_o
);
  logic [4:0] shamt;
  assign shamt = operand2_i[4:0];
  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_AND: result_o = operand1_i & operand2_i;
      ALU_OR:  result_o = operand1_i | operand2_i;
      ALU_ADD: result_o = operand1_i + operand2_i;
      ALU_XOR: result_o = operand1_i ^ operand2_i;
      ALU_SUB: result_o = operand1_i - operand2_i;
      ALU_SLL: result_o = operand1_i << shamt;
      ALU_SRL: result_o = operand1_i >> shamt;
      ALU_SRA: result_o = $unsigned($signed(operand1_i) >>> shamt);
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with a registered response
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);
  logic              can_accept, grant0, grant1, acc, ill_d, valid_d, ptr_d;
  logic [DATA_W-1:0] op1, op2, alu_res, res_d;
  logic [3:0]        ctrl;
  logic              ptr_q, valid_q, id_q, zero_q, neg_q, ill_q;
  logic [DATA_W-1:0] result_q;
  always_comb begin
    can_accept = !valid_q || bus.i_rsp_ready;
    grant0     = bus.i_r0_valid && (!bus.i_r1_valid || !ptr_q);
    grant1     = bus.i_r1_valid && (!bus.i_r0_valid || ptr_q);
    acc        = (grant0 || grant1) && can_accept;
    ptr_d      = acc ? grant0 : ptr_q;
    op1        = grant1 ? bus.i_r1_operand1 : bus.i_r0_operand1;
    op2        = grant1 ? bus.i_r1_operand2 : bus.i_r0_operand2;
    ctrl       = grant1 ? bus.i_r1_ALUControl : bus.i_r0_ALUControl;
    ill_d      = !is_legal_op(ctrl);
    res_d      = ill_d ? '0 : alu_res;
    valid_d    = acc || (valid_q && !bus.i_rsp_ready);
  end
  ALU u_alu (
    .operand1_i    (op1),
    .operand2_i    (op2),
    .alu_control_i (ctrl),
    .result_o      (alu_res)
  );
  // payload only loads on accept so it holds steady while the consumer stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q    <= RESET_PRIO;
      valid_q  <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      if (acc) begin
        id_q     <= grant1;
        result_q <= res_d;
        zero_q   <= res_d == '0;
        neg_q    <= res_d[DATA_W-1];
        ill_q    <= ill_d;
      end
    end
  end
  assign bus.o_r0_ready    = grant0 && can_accept;
  assign bus.o_r1_ready    = grant1 && can_accept;
  assign bus.o_rsp_valid   = valid_q;
  assign bus.o_rsp_id      = id_q;
  assign bus.o_rsp_result  = result_q;
  assign bus.o_rsp_zero    = zero_q;
  assign bus.o_rsp_neg     = neg_q;
  assign bus.o_rsp_illegal = ill_q;
  assign bus.o_busy        = valid_q && !bus.i_rsp_ready;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  bit m_vld, m_prio, m_id, m_zero, m_neg, m_ill, acc0, acc1;
  logic [31:0] m_res;
  alu_arbiter_if bus();
  alu_arbiter #(.RESET_PRIO(1'b0)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, a + b};
      4'd3:    return {1'b0, a ^ b};
      4'd6:    return {1'b0, a - b};
      4'd8:    return {1'b0, a << s};
      4'd9:    return {1'b0, a >> s};
      4'd10:   return {1'b0, (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
  task automatic set_req(input int n, input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.i_r0_valid = v; bus.i_r0_ALUControl = op; bus.i_r0_operand1 = a; bus.i_r0_operand2 = b;
    end else begin
      bus.i_r1_valid = v; bus.i_r1_ALUControl = op; bus.i_r1_operand1 = a; bus.i_r1_operand2 = b;
    end
  endtask
  task automatic model_reset();
    m_vld = 0; m_prio = 0; acc0 = 0; acc1 = 0;
  endtask
  task automatic rst_check();
    check("rst_valid", bus.o_rsp_valid, 0);
    check("rst_id", bus.o_rsp_id, 0);
    check("rst_result", bus.o_rsp_result, 0);
    check("rst_zero", bus.o_rsp_zero, 0);
    check("rst_neg", bus.o_rsp_neg, 0);
    check("rst_illegal", bus.o_rsp_illegal, 0);
    check("rst_busy", bus.o_busy, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, 4'd0, 0, 0);
    set_req(1, 0, 4'd0, 0, 0);
    #1 rst_check();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  // one clock: check handshake outputs, advance the model at the edge, check the response
  task automatic cycle();
    bit can, g0, g1;
    logic [32:0] r;
    #1;
    can = !m_vld || bus.i_rsp_ready;
    g0 = bus.i_r0_valid && (!bus.i_r1_valid || !m_prio);
    g1 = bus.i_r1_valid && (!bus.i_r0_valid || m_prio);
    check("r0_ready", bus.o_r0_ready, g0 && can);
    check("r1_ready", bus.o_r1_ready, g1 && can);
    check("busy", bus.o_busy, m_vld && !bus.i_rsp_ready);
    r = g1 ? ref_alu(bus.i_r1_ALUControl, bus.i_r1_operand1, bus.i_r1_operand2)
           : ref_alu(bus.i_r0_ALUControl, bus.i_r0_operand1, bus.i_r0_operand2);
    @(posedge clk);
    acc0 = g0 && can;
    acc1 = g1 && can;
    if (acc0 || acc1) begin
      m_vld = 1; m_id = acc1; m_prio = acc0;
      m_res = r[31:0]; m_ill = r[32]; m_zero = (r[31:0] == 0); m_neg = r[31];
    end else if (bus.i_rsp_ready) m_vld = 0;
    @(negedge clk);
    check("rsp_valid", bus.o_rsp_valid, m_vld);
    if (m_vld) begin
      check("rsp_id", bus.o_rsp_id, m_id);
      check("rsp_result", bus.o_rsp_result, m_res);
      check("rsp_zero", bus.o_rsp_zero, m_zero);
      check("rsp_neg", bus.o_rsp_neg, m_neg);
      check("rsp_illegal", bus.o_rsp_illegal, m_ill);
    end
  endtask
  logic [3:0] legal [8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA};
  initial begin
    bus.i_rsp_ready = 1'b0;
    set_req(0, 0, 4'd0, 0, 0);
    set_req(1, 0, 4'd0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_check();
    check("rst_r0_ready_idle", bus.o_r0_ready, 0);
    bus.i_r1_valid = 1'b1;
    #1;
    check("rst_r1_ready_follow", bus.o_r1_ready, 1);
    check("rst_r0_ready_low", bus.o_r0_ready, 0);
    bus.i_r1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, ALU_ADD, 5, 7);
    bus.i_rsp_ready = 1'b1;
    cycle();
    check("add_result", bus.o_rsp_result, 12);
    set_req(0, 0, ALU_ADD, 0, 0);
    cycle();
    do_reset();
    set_req(0, 1, ALU_SUB, 3, 3);
    set_req(1, 1, ALU_OR, 32'hF0, 32'h0F);
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("cont_id", bus.o_rsp_id, i % 2);
      check("cont_result", bus.o_rsp_result, (i % 2) ? 32'hFF : 32'h0);
    end
    bus.i_rsp_ready = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_busy", bus.o_busy, 1);
      check("bp_hold_result", bus.o_rsp_result, 32'hFF);
    end
    bus.i_rsp_ready = 1'b1;
    cycle();
    check("bp_resume_id", bus.o_rsp_id, 0);
    set_req(0, 0, ALU_ADD, 0, 0);
    set_req(1, 1, 4'b0100, 32'h1234, 32'h5678);
    cycle();
    check("ill_flag", bus.o_rsp_illegal, 1);
    check("ill_zero", bus.o_rsp_zero, 1);
    check("ill_id", bus.o_rsp_id, 1);
    set_req(1, 0, ALU_ADD, 0, 0);
    set_req(0, 1, ALU_SUB, 1, 2);
    cycle();
    check("neg_result", bus.o_rsp_result, 32'hFFFF_FFFF);
    check("neg_flag", bus.o_rsp_neg, 1);
    set_req(0, 1, ALU_SLL, 1, 4);
    cycle();
    check("sll_result", bus.o_rsp_result, 16);
    set_req(0, 1, ALU_SRL, 32'h8000_0000, 31);
    cycle();
    check("srl_result", bus.o_rsp_result, 1);
    set_req(0, 0, ALU_ADD, 0, 0);
    cycle();
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++) begin
        bit cur_v, was_acc;
        logic [3:0] op;
        logic [31:0] a, b;
        cur_v = (n == 0) ? bus.i_r0_valid : bus.i_r1_valid;
        was_acc = (n == 0) ? acc0 : acc1;
        if (!cur_v || was_acc) begin
          op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : 4'($urandom);
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
          if ($urandom_range(0, 7) == 0) b = a;
          set_req(n, $urandom_range(0, 3) != 0, op, a, b);
        end
      end
      bus.i_rsp_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    set_req(1, 0, ALU_ADD, 0, 0);
    set_req(0, 1, ALU_ADD, 1, 1);
    bus.i_rsp_ready = 1'b1;
    cycle();
    bus.i_rsp_ready = 1'b0;
    set_req(0, 0, ALU_ADD, 0, 0);
    check("pre_rst_valid", bus.o_rsp_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.o_rsp_valid, 0);
    check("async_rst_result", bus.o_rsp_result, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, ALU_XOR, 32'hA5, 32'h5A);
    set_req(1, 1, ALU_AND, 32'hFF, 32'h0F);
    bus.i_rsp_ready = 1'b1;
    cycle();
    check("ptr_after_rst", bus.o_rsp_id, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
